// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
//   Bundles the core <-> data-memory handshake into one interface.
//
//   Request side (core -> memory, the mem_in_s fields plus the byte address):
//     addr              byte address, sampled when the request is accepted
//     in_write_data     store data (SW: all 32 bits, SB: bits [7:0])
//     in_valid          request present
//     in_wen            1 = store, 0 = load
//     in_byte_not_word  1 = byte access (SB/LBU), 0 = word access (SW/LW)
//     in_yumi           core consumes the pending read response
//
//   Response side (memory -> core, the mem_out_s fields):
//     out_read_data     load result, stable while out_valid is high
//     out_valid         read response present
//     out_yumi          request accepted this cycle
//
//   Handshake semantics: a request transfers on a rising clk edge where
//   in_valid and out_yumi are both high (out_yumi is a combinational function
//   of in_valid and the responder being idle). A read response transfers on a
//   rising edge where out_valid and in_yumi are both high; out_valid and
//   out_read_data hold their values until that edge. in_yumi is meaningless
//   while out_valid is low, and in_valid is ignored (not queued) while a read
//   is outstanding.
//
//   Modports: master = core side, slave = memory side.
// -----------------------------------------------------------------------------
interface data_mem_responder_if #(
    parameter int ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           in_write_data;
    logic                  in_valid;
    logic                  in_wen;
    logic                  in_byte_not_word;
    logic                  in_yumi;
    logic [31:0]           out_read_data;
    logic                  out_valid;
    logic                  out_yumi;

    modport master (
        output addr,
        output in_write_data,
        output in_valid,
        output in_wen,
        output in_byte_not_word,
        output in_yumi,
        input  out_read_data,
        input  out_valid,
        input  out_yumi
    );

    modport slave (
        input  addr,
        input  in_write_data,
        input  in_valid,
        input  in_wen,
        input  in_byte_not_word,
        input  in_yumi,
        output out_read_data,
        output out_valid,
        output out_yumi
    );
endinterface

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//   Leaf data memory behind the core's dmem port. Holds a word-organised RAM
//   of 2**(ADDR_WIDTH-2) 32-bit words and serves LW/LBU reads and SW/SB
//   writes. Writes commit on the accept edge (one per cycle); reads return
//   after a programmable latency so the core's stall logic gets exercised.
//
//   Parameters:
//     ADDR_WIDTH    byte-address width
//     READ_LATENCY  cycles from the accept edge until out_valid rises (1..15)
//
//   Ports:
//     clk        single clock, all logic on posedge
//     reset      synchronous, active-high
//     mem        data_mem_responder_if.slave (request in, response out)
//     state_dbg  current FSM state (IDLE=0, BUSY=1, RESP=2)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    data_mem_responder_if.slave   mem,
    output logic [1:0]            state_dbg
);

    localparam int WORD_W = ADDR_WIDTH - 2;
    localparam int DEPTH  = 2 ** WORD_W;

    // Countdown preload: the BUSY state lasts READ_LATENCY-1 cycles.
    localparam logic [3:0] LAT_INIT = 4'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        count;
    logic [3:0]        count_next;

    // Read request captured at accept time
    logic [WORD_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              byte_sel;
    logic [31:0]       read_data;

    logic [31:0]       ram [DEPTH];

    logic              accept;
    logic              write_fire;
    logic              read_fire;
    logic              load_resp;

    logic [WORD_W-1:0] req_idx;
    logic [1:0]        req_lane;

    logic [WORD_W-1:0] rd_idx;
    logic [1:0]        rd_lane;
    logic              rd_byte;
    logic [31:0]       rd_word;
    logic [7:0]        rd_lane_byte;
    logic [31:0]       rd_value;

    assign req_idx  = mem.addr[ADDR_WIDTH-1:2];
    assign req_lane = mem.addr[1:0];

    // -------------------------------------------------------------------------
    // Next-state / control
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        count_next = count;
        accept     = 1'b0;
        write_fire = 1'b0;
        read_fire  = 1'b0;
        load_resp  = 1'b0;

        case (state)
            IDLE: begin
                // A request arriving together with reset is refused outright.
                accept = mem.in_valid && !reset;
                if (accept) begin
                    if (mem.in_wen) begin
                        write_fire = 1'b1;
                    end else begin
                        read_fire  = 1'b1;
                        count_next = LAT_INIT;
                        if (READ_LATENCY == 1) begin
                            state_next = RESP;
                            load_resp  = 1'b1;
                        end else begin
                            state_next = BUSY;
                        end
                    end
                end
            end

            BUSY: begin
                count_next = count - 4'd1;
                if (count == 4'd1) begin
                    state_next = RESP;
                    load_resp  = 1'b1;
                    count_next = 4'd0;
                end
            end

            RESP: begin
                if (mem.in_yumi) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Read data path. With a one-cycle latency the RAM is read on the accept
    // edge itself, so the live request fields are used; otherwise the fields
    // latched at accept time select the word.
    // -------------------------------------------------------------------------
    always_comb begin
        if (state == IDLE) begin
            rd_idx  = req_idx;
            rd_lane = req_lane;
            rd_byte = mem.in_byte_not_word;
        end else begin
            rd_idx  = word_idx;
            rd_lane = lane;
            rd_byte = byte_sel;
        end
    end

    assign rd_word = ram[rd_idx];

    // Little-endian lanes: lane 0 is bits [7:0]
    always_comb begin
        case (rd_lane)
            2'd0:    rd_lane_byte = rd_word[7:0];
            2'd1:    rd_lane_byte = rd_word[15:8];
            2'd2:    rd_lane_byte = rd_word[23:16];
            default: rd_lane_byte = rd_word[31:24];
        endcase
    end

    assign rd_value = rd_byte ? {24'd0, rd_lane_byte} : rd_word;

    // -------------------------------------------------------------------------
    // State and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            word_idx  <= '0;
            lane      <= 2'd0;
            byte_sel  <= 1'b0;
            read_data <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
            if (read_fire) begin
                word_idx <= req_idx;
                lane     <= req_lane;
                byte_sel <= mem.in_byte_not_word;
            end
            // Sampled on RESP entry so the read sees every earlier write.
            if (load_resp) begin
                read_data <= rd_value;
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port. Contents are not cleared by reset; write_fire is already
    // gated by reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (write_fire) begin
            if (mem.in_byte_not_word) begin
                case (req_lane)
                    2'd0:    ram[req_idx][7:0]   <= mem.in_write_data[7:0];
                    2'd1:    ram[req_idx][15:8]  <= mem.in_write_data[7:0];
                    2'd2:    ram[req_idx][23:16] <= mem.in_write_data[7:0];
                    default: ram[req_idx][31:24] <= mem.in_write_data[7:0];
                endcase
            end else begin
                ram[req_idx] <= mem.in_write_data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign mem.out_yumi      = accept;
    assign mem.out_valid     = (state == RESP);
    assign mem.out_read_data = read_data;
    assign state_dbg         = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//   Three responder instances sharing one clock, built with read latencies
//   2, 1 and 15. Directed scenarios followed by random SW/SB/LW/LBU traffic,
//   each read checked against a word-array model of the memory.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam int AW = 12;
    localparam int N  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst      [N];
    logic [AW-1:0]  addr     [N];
    logic [31:0]    wdata    [N];
    logic           in_valid [N];
    logic           wen      [N];
    logic           bnw      [N];
    logic           in_yumi  [N];
    logic [31:0]    rdata    [N];
    logic           out_valid[N];
    logic           out_yumi [N];
    logic [1:0]     st       [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int LAT_G = (g == 0) ? 2 : ((g == 1) ? 1 : 15);

        data_mem_responder_if #(.ADDR_WIDTH(AW)) bus ();

        assign bus.addr             = addr[g];
        assign bus.in_write_data    = wdata[g];
        assign bus.in_valid         = in_valid[g];
        assign bus.in_wen           = wen[g];
        assign bus.in_byte_not_word = bnw[g];
        assign bus.in_yumi          = in_yumi[g];
        assign rdata[g]             = bus.out_read_data;
        assign out_valid[g]         = bus.out_valid;
        assign out_yumi[g]          = bus.out_yumi;

        data_mem_responder #(
            .ADDR_WIDTH  (AW),
            .READ_LATENCY(LAT_G)
        ) dut (
            .clk      (clk),
            .reset    (rst[g]),
            .mem      (bus.slave),
            .state_dbg(st[g])
        );
    end

    // Reference memory: one word array per instance
    logic [31:0] model [N][1024];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input int d, input logic [AW-1:0] a, input bit is_byte);
        logic [31:0] w;
        w = model[d][a[AW-1:2]];
        if (is_byte) return (w >> (8 * a[1:0])) & 32'hFF;
        return w;
    endfunction

    task automatic ref_write(input int d, input logic [AW-1:0] a, input logic [31:0] data, input bit is_byte);
        logic [31:0] mask;
        if (is_byte) begin
            mask = 32'hFF << (8 * a[1:0]);
            model[d][a[AW-1:2]] = (model[d][a[AW-1:2]] & ~mask) | ((data & 32'hFF) << (8 * a[1:0]));
        end else begin
            model[d][a[AW-1:2]] = data;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic clear_inputs(input int d);
        addr[d]     = '0;
        wdata[d]    = 32'd0;
        in_valid[d] = 1'b0;
        wen[d]      = 1'b0;
        bnw[d]      = 1'b0;
        in_yumi[d]  = 1'b0;
    endtask

    // Presents a store for one cycle; leaves it asserted so the caller can
    // chain another request on the next cycle or call release_req.
    task automatic do_write(input int d, input logic [AW-1:0] a, input logic [31:0] data, input bit is_byte);
        @(negedge clk);
        addr[d]     = a;
        wdata[d]    = data;
        in_valid[d] = 1'b1;
        wen[d]      = 1'b1;
        bnw[d]      = is_byte;
        in_yumi[d]  = 1'b0;
        #1;
        check($sformatf("wr_yumi d%0d a%03h", d, a), 32'(out_yumi[d]), 32'd1);
        ref_write(d, a, data, is_byte);
    endtask

    task automatic release_req(input int d);
        @(negedge clk);
        in_valid[d] = 1'b0;
        wen[d]      = 1'b0;
    endtask

    // Full read transaction: accept, measure latency, hold the response for
    // `hold` cycles while poking new requests, then consume it.
    task automatic do_read(input int d, input logic [AW-1:0] a, input bit is_byte,
                           input int hold, output logic [31:0] got);
        logic [31:0] exp;
        int          k;
        string       tg;
        tg = $sformatf("d%0d a%03h b%0d", d, a, is_byte);
        @(negedge clk);
        addr[d]     = a;
        wdata[d]    = $urandom;
        in_valid[d] = 1'b1;
        wen[d]      = 1'b0;
        bnw[d]      = is_byte;
        in_yumi[d]  = 1'b0;
        #1;
        check({"rd_yumi ", tg}, 32'(out_yumi[d]), 32'd1);
        exp = ref_read(d, a, is_byte);
        k = 0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            @(negedge clk);
            // Requests and stray yumi while a read is in flight must be ignored
            in_valid[d] = 1'($urandom_range(0, 1));
            wen[d]      = 1'($urandom_range(0, 1));
            in_yumi[d]  = 1'b0;
            #1;
            if (out_valid[d]) k = i;
        end
        check({"rd_latency ", tg}, 32'(k), 32'(lat_of(d)));
        check({"rd_data ", tg}, rdata[d], exp);
        got = rdata[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid[d] = 1'b1;
            in_yumi[d]  = 1'b0;
            #1;
            check({"hold_valid ", tg}, 32'(out_valid[d]), 32'd1);
            check({"hold_data ", tg}, rdata[d], exp);
            check({"hold_no_yumi ", tg}, 32'(out_yumi[d]), 32'd0);
        end
        @(negedge clk);
        in_yumi[d]  = 1'b1;
        in_valid[d] = 1'b1;
        #1;
        check({"consume_no_accept ", tg}, 32'(out_yumi[d]), 32'd0);
        @(negedge clk);
        in_yumi[d]  = 1'b0;
        in_valid[d] = 1'b0;
        wen[d]      = 1'b0;
        #1;
        check({"consume_valid_low ", tg}, 32'(out_valid[d]), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]   got;
        logic [AW-1:0] a;
        logic [31:0]   data;
        int            op;
        int            bad;

        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1;
            clear_inputs(d);
        end
        // Request held during reset must not be accepted
        in_valid[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < N; d++) begin
            check($sformatf("reset_read_data d%0d", d), rdata[d], 32'd0);
            check($sformatf("reset_valid d%0d", d), 32'(out_valid[d]), 32'd0);
            check($sformatf("reset_yumi d%0d", d), 32'(out_yumi[d]), 32'd0);
            check($sformatf("reset_state d%0d", d), 32'(st[d]), 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b0;
            clear_inputs(d);
        end

        // 1: SW then LW, latency 2
        do_write(0, 12'h010, 32'hDEADBEEF, 1'b0);
        do_read(0, 12'h010, 1'b0, 0, got);
        check("t1_lw", got, 32'hDEADBEEF);

        // 2: SB merges into one lane; upper write_data bits ignored
        do_write(0, 12'h020, 32'h11223344, 1'b0);
        do_write(0, 12'h022, 32'hFFFFFFAB, 1'b1);
        release_req(0);
        do_read(0, 12'h020, 1'b0, 0, got);
        check("t2_lw", got, 32'h11AB3344);
        do_read(0, 12'h023, 1'b1, 0, got);
        check("t2_lbu", got, 32'h00000011);
        do_read(0, 12'h021, 1'b1, 1, got);
        check("t2_lbu_lane1", got, 32'h00000033);

        // 3: response held 5 cycles while the core withholds yumi
        do_read(0, 12'h013, 1'b0, 5, got);
        check("t3_lw_unaligned", got, 32'hDEADBEEF);

        // 4: back-to-back word writes
        do_write(0, 12'h000, 32'hA5A5_0001, 1'b0);
        do_write(0, 12'h004, 32'h5A5A_0002, 1'b0);
        do_write(0, 12'h008, 32'hC3C3_0003, 1'b0);
        release_req(0);
        do_read(0, 12'h000, 1'b0, 0, got);
        check("t4_rd0", got, 32'hA5A5_0001);
        do_read(0, 12'h004, 1'b0, 0, got);
        check("t4_rd1", got, 32'h5A5A_0002);
        do_read(0, 12'h008, 1'b0, 0, got);
        check("t4_rd2", got, 32'hC3C3_0003);

        // 5: top word on every latency build
        for (int d = 0; d < N; d++) begin
            do_write(d, 12'hFFC, 32'hCAFE_0000 + 32'(d), 1'b0);
            do_write(d, 12'hFFF, 32'h0000_0077, 1'b1);
            release_req(d);
            do_read(d, 12'hFFC, 1'b0, 1, got);
            check($sformatf("t5_top_lw d%0d", d), got, {8'h77, 8'hFE, 8'h00, 8'(d)});
            do_read(d, 12'hFFF, 1'b1, 0, got);
            check($sformatf("t5_top_lbu d%0d", d), got, 32'h0000_0077);
        end

        // 6a: reset with a write request -> refused, not committed
        @(negedge clk);
        rst[0]      = 1'b1;
        addr[0]     = 12'h010;
        wdata[0]    = 32'h0BAD_F00D;
        in_valid[0] = 1'b1;
        wen[0]      = 1'b1;
        bnw[0]      = 1'b0;
        #1;
        check("t6_reset_write_yumi", 32'(out_yumi[0]), 32'd0);
        @(negedge clk);
        rst[0] = 1'b0;
        clear_inputs(0);
        do_read(0, 12'h010, 1'b0, 0, got);
        check("t6_reset_write_dropped", got, 32'hDEADBEEF);

        // 6b: reset while BUSY (latency 15) drops the read
        do_write(2, 12'h010, 32'h1357_9BDF, 1'b0);
        @(negedge clk);
        addr[2]     = 12'h010;
        wen[2]      = 1'b0;
        bnw[2]      = 1'b0;
        in_valid[2] = 1'b1;
        #1;
        check("t6_busy_accept", 32'(out_yumi[2]), 32'd1);
        @(negedge clk);
        in_valid[2] = 1'b0;
        repeat (3) @(negedge clk);
        rst[2] = 1'b1;
        @(negedge clk);
        rst[2] = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (out_valid[2] !== 1'b0) bad++;
        end
        check("t6_busy_no_valid", 32'(bad), 32'd0);
        check("t6_busy_read_data", rdata[2], 32'd0);
        do_read(2, 12'h010, 1'b0, 0, got);
        check("t6_after_reset_lw", got, 32'h1357_9BDF);

        // Random traffic over a small window, preloaded so reads hit known data
        for (int d = 0; d < N; d++) begin
            for (int w = 0; w < 16; w++) begin
                do_write(d, AW'(w * 4), $urandom, 1'b0);
            end
            release_req(d);
            for (int t = 0; t < 40; t++) begin
                op   = $urandom_range(0, 3);
                a    = AW'($urandom_range(0, 63));
                data = $urandom;
                case (op)
                    0: do_write(d, a, data, 1'b0);
                    1: do_write(d, a, data, 1'b1);
                    2: do_read(d, a, 1'b0, $urandom_range(0, 3), got);
                    default: do_read(d, a, 1'b1, $urandom_range(0, 3), got);
                endcase
            end
            release_req(d);
            for (int w = 0; w < 16; w++) begin
                do_read(d, AW'(w * 4), 1'b0, 0, got);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
